// File: rtl/im_loader.sv
// im_loader: assembles framed host-link bytes into 16-bit instruction-memory writes.
// Define IM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module im_loader #(
  parameter logic [15:0] CODE_BASE = 16'h0000,
  parameter logic [15:0] DICT_BASE = 16'h1000,
  parameter int unsigned MAX_WORDS = 2048,
  parameter logic [7:0]  HDR_CODE  = 8'hA5,
  parameter logic [7:0]  HDR_DICT  = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        we,
  output logic [15:0] waddr,
  output logic [15:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

`ifdef IM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_H, LEN_L, DATA_H, DATA_L} state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [15:0] base;
  logic [15:0] word_cnt;
  logic [15:0] len_word;
  logic [11:0] word_idx;
  logic [11:0] idx_next;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [7:0]  xor_acc;
  logic        last_word;
  logic        load_hdr;
  logic        len_err;
  logic        chk_bad;
  logic        write_word;
  logic        finish;
`ifndef IM_LOADER_CHECKSUM_EN
  logic        last_q;
`endif

  assign in_ready  = ~reset;
  assign accept    = in_valid & in_ready;
  assign len_word  = {len_hi, in_data};
  assign idx_next  = word_idx + 12'd1;
  assign last_word = ({4'd0, idx_next} == word_cnt);
  // The trailing write cycle still holds the CPU even though the FSM is back in IDLE.
  assign cpu_hold  = (state != IDLE) | we;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_hdr   = 1'b0;
    len_err    = 1'b0;
    chk_bad    = 1'b0;
    write_word = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && (in_data == HDR_CODE || in_data == HDR_DICT)) begin
          load_hdr   = 1'b1;
          state_next = LEN_H;
        end
      end
      LEN_H: begin
        if (accept) state_next = LEN_L;
      end
      LEN_L: begin
        if (accept) begin
          if (len_word > 16'(MAX_WORDS)) begin
            len_err    = 1'b1;
            state_next = IDLE;
          end else if (len_word == 16'd0) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            finish     = 1'b1;
            state_next = IDLE;
`endif
          end else begin
            state_next = DATA_H;
          end
        end
      end
      DATA_H: begin
        if (accept) state_next = DATA_L;
      end
      DATA_L: begin
        if (accept) begin
          write_word = 1'b1;
          if (last_word) begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_next = CHK;
`else
            state_next = IDLE;
`endif
          end else begin
            state_next = DATA_H;
          end
        end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_next = IDLE;
          if (in_data == xor_acc) finish  = 1'b1;
          else                    chk_bad = 1'b1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Datapath: write strobe, address/data, length and checksum bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      we       <= 1'b0;
      waddr    <= 16'd0;
      wdata    <= 16'd0;
      done     <= 1'b0;
      err      <= 1'b0;
      base     <= 16'd0;
      word_cnt <= 16'd0;
      word_idx <= 12'd0;
      len_hi   <= 8'd0;
      data_hi  <= 8'd0;
      xor_acc  <= 8'd0;
`ifndef IM_LOADER_CHECKSUM_EN
      last_q   <= 1'b0;
`endif
    end else begin
      we <= write_word;
`ifdef IM_LOADER_CHECKSUM_EN
      done <= finish;
`else
      // Without a checksum byte, done trails the final write strobe by one cycle.
      last_q <= write_word & last_word;
      done   <= finish | last_q;
`endif
      if (load_hdr) begin
        base     <= (in_data == HDR_CODE) ? CODE_BASE : DICT_BASE;
        word_idx <= 12'd0;
        xor_acc  <= 8'd0;
        err      <= 1'b0;
      end
      if (len_err | chk_bad) err <= 1'b1;
      if (accept && state == LEN_H) len_hi <= in_data;
      if (accept && state == LEN_L) word_cnt <= len_word;
      if (accept && state == DATA_H) begin
        data_hi <= in_data;
        xor_acc <= xor_acc ^ in_data;
      end
      if (write_word) begin
        wdata    <= {data_hi, in_data};
        waddr    <= base + {3'd0, word_idx, 1'b0};
        word_idx <= idx_next;
        xor_acc  <= xor_acc ^ in_data;
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Testbench for im_loader: directed byte frames with a write scoreboard.
// Adapts to IM_LOADER_CHECKSUM_EN (sends checksum bytes and runs checksum cases).
`timescale 1ns/1ps
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w;
  logic        prev_we = 1'b0;
  logic [7:0]  frame2[5] = '{8'h5A, 8'h00, 8'h01, 8'hDE, 8'hAD};

  im_loader dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expectWrite(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called right after the last low byte of a frame with data words.
  task automatic finishFrame(input logic [7:0] chk, input string tag);
    checkOutput({tag, "_we_latency"}, {31'd0, we}, 32'd1);
    checkOutput({tag, "_hold_trailing"}, {31'd0, cpu_hold}, 32'd1);
`ifdef IM_LOADER_CHECKSUM_EN
    applyStimulus(chk);
`else
    in_data = chk;
    tick();
`endif
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_hold_fall"}, {31'd0, cpu_hold}, 32'd0);
    checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
    tick();
    checkOutput({tag, "_done_once"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_all_written"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && we) begin
      checkOutput("we_single_cycle", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("write_expected", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_w = exp_q.pop_front();
        checkOutput("write_addr", {16'd0, waddr}, {16'd0, exp_w[31:16]});
        checkOutput("write_data", {16'd0, wdata}, {16'd0, exp_w[15:0]});
      end
    end
    prev_we = we;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick();
    tick();
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_we", {31'd0, we}, 32'd0);
    checkOutput("rst_waddr", {16'd0, waddr}, 32'd0);
    checkOutput("rst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    tick();

    $display("[TB] frame 1: code region, two words");
    expectWrite(16'h0000, 16'h1234);
    expectWrite(16'h0002, 16'hABCD);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'hAB);
    applyStimulus(8'hCD);
    finishFrame(8'h40, "f1");

    $display("[TB] frame 2: dict region, hold across frame");
    expectWrite(16'h1000, 16'hDEAD);
    checkOutput("f2_hold_before", {31'd0, cpu_hold}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(frame2[i]);
      checkOutput("f2_hold_in_frame", {31'd0, cpu_hold}, 32'd1);
    end
    finishFrame(8'h73, "f2");

    $display("[TB] frame 3: length overflow then recovery");
    applyStimulus(8'hA5);
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    checkOutput("ovf_err", {31'd0, err}, 32'd1);
    checkOutput("ovf_idle", {31'd0, cpu_hold}, 32'd0);
    checkOutput("ovf_done", {31'd0, done}, 32'd0);
    tick();
    checkOutput("ovf_err_sticky", {31'd0, err}, 32'd1);
    expectWrite(16'h0000, 16'h5566);
    applyStimulus(8'hA5);
    checkOutput("hdr_clears_err", {31'd0, err}, 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h55);
    applyStimulus(8'h66);
    finishFrame(8'h33, "f3");

    $display("[TB] frame 4: garbage ignored in IDLE");
    applyStimulus(8'h00);
    checkOutput("garbage_hold0", {31'd0, cpu_hold}, 32'd0);
    applyStimulus(8'hFF);
    checkOutput("garbage_hold1", {31'd0, cpu_hold}, 32'd0);
    applyStimulus(8'h13);
    checkOutput("garbage_hold2", {31'd0, cpu_hold}, 32'd0);
    expectWrite(16'h0000, 16'h0FF0);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h0F);
    applyStimulus(8'hF0);
    finishFrame(8'hFF, "f4");

    $display("[TB] frame 5: reset mid-frame");
    expectWrite(16'h0000, 16'h1122);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    reset = 1'b1;
    #1;
    checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    checkOutput("midrst_we", {31'd0, we}, 32'd0);
    checkOutput("midrst_waddr", {16'd0, waddr}, 32'd0);
    checkOutput("midrst_wdata", {16'd0, wdata}, 32'd0);
    checkOutput("midrst_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_err", {31'd0, err}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("midrst_ready_back", {31'd0, in_ready}, 32'd1);
    applyStimulus(8'h44);
    tick();
    tick();
    checkOutput("midrst_abandoned", {31'd0, cpu_hold}, 32'd0);
    checkOutput("midrst_one_write", 32'(exp_q.size()), 32'd0);

`ifdef IM_LOADER_CHECKSUM_EN
    $display("[TB] checksum cases");
    expectWrite(16'h0000, 16'h1234);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h00);
    checkOutput("chk_bad_err", {31'd0, err}, 32'd1);
    checkOutput("chk_bad_done", {31'd0, done}, 32'd0);
    checkOutput("chk_bad_written", 32'(exp_q.size()), 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h26);
    checkOutput("chk_empty_bad_err", {31'd0, err}, 32'd1);
    checkOutput("chk_empty_bad_done", {31'd0, done}, 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("chk_empty_ok_done", {31'd0, done}, 32'd1);
    checkOutput("chk_empty_ok_err", {31'd0, err}, 32'd0);
`else
    $display("[TB] zero-length frame");
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("empty_done", {31'd0, done}, 32'd1);
    checkOutput("empty_hold", {31'd0, cpu_hold}, 32'd0);
    checkOutput("empty_err", {31'd0, err}, 32'd0);
`endif
    tick();
    tick();
    checkOutput("final_no_pending", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Byte-stream program loader; the write side of the 16-bit instruction memory.
- Takes framed bytes from the host link (UART receiver output) and assembles them into 16-bit instruction words.
- Emits one write per word into the code region (words 0–2047) or the dict region (words 2048–4095).
- Holds the CPU while a frame is in progress.

Parameters:
- CODE_BASE, 16'h0000, byte address of code region (word 0)
- DICT_BASE, 16'h1000, byte address of dict region (word 2048)
- MAX_WORDS, 2048, maximum words per frame (region size)
- HDR_CODE, 8'hA5, header byte selecting code region
- HDR_DICT, 8'h5A, header byte selecting dict region

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  8  received byte
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  byte accepted when in_valid & in_ready
- we  out  1  one-cycle instruction-memory write strobe
- waddr  out  16  byte address (PC format, bit0 = 0; memory indexes waddr[13:1])
- wdata  out  16  instruction word
- cpu_hold  out  1  high while a frame is active (IDLE excluded)
- done  out  1  one-cycle pulse, frame completed without error
- err  out  1  sticky error flag, cleared by the next valid header

Behaviour:
- Reset (synchronous, applies mid-frame too): state IDLE; we=0, waddr=0, wdata=0, cpu_hold=0, done=0, err=0, in_ready=0 during reset cycle then 1. A partial frame is abandoned with no further writes.
- in_ready=1 in every non-reset cycle; loader never stalls the link.
- Frame bytes, in order:
  - header
  - length high byte, length low byte (word count N, big-endian)
  - N words, each high byte then low byte
  - checksum byte (see Optional Feature)
- States: IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK.
- IDLE:
  - HDR_CODE → base=CODE_BASE; HDR_DICT → base=DICT_BASE. Either clears err, clears word index and XOR accumulator, goes to LEN_H.
  - Any other byte is ignored.
- LEN_H → LEN_L; LEN_L latches N:
  - N > MAX_WORDS: err=1, go to IDLE, no writes.
  - N = 0: go to CHK (or IDLE with done when feature off).
  - Otherwise go to DATA_H.
- DATA_H latches high byte → DATA_L.
- DATA_L accept at cycle t: at t+1, we=1, wdata={hi,lo}, waddr=base + 2*index. Index increments.
  - If index reached N: go to CHK (or finish).
  - Else go to DATA_H.
- Write latency: exactly 1 cycle after low-byte acceptance. we is never high on consecutive cycles for one word.
- Data bytes only (not header/length) are XORed into an 8-bit accumulator.
- Address arithmetic: 16-bit, index < 2048, so a frame never crosses a region boundary. waddr holds its last value when we=0.
- Finish: done pulses 1 cycle, state IDLE, cpu_hold falls in the same cycle done is high.
- cpu_hold = 1 in LEN_H..CHK; also 1 in the cycle of a trailing write.
- No timeout: an idle link mid-frame holds state indefinitely.

Optional Feature:
- Macro IM_LOADER_CHECKSUM_EN.
- Defined:
  - CHK state expects one byte equal to the XOR of all data bytes.
  - Match → done pulse. Mismatch → err=1, no done.
  - Words are already written either way; err tells the host to resend.
- Undefined:
  - CHK state does not exist; frame ends after the last low byte (or after LEN_L when N=0).
  - done pulses in the cycle after the final write strobe. err is set only by length overflow.

Test Plan:
- Reset then bytes A5 00 02 12 34 AB CD [chk 0x40] → we at waddr 0x0000 data 0x1234, then waddr 0x0002 data 0xABCD; done=1 once, err=0.
- Bytes 5A 00 01 DE AD [chk 0x73] → we at waddr 0x1000 data 0xDEAD; cpu_hold high from header to done.
- Bytes A5 08 01 → err=1, no we, IDLE; then a valid frame clears err and writes normally.
- Garbage 00 FF 13 in IDLE → no state change, cpu_hold=0; a following A5 frame loads correctly.
- Reset asserted after A5 00 03 11 22 33 → one write (0x1122 @0x0000), none after reset; all outputs return to reset values.
- With IM_LOADER_CHECKSUM_EN: A5 00 01 12 34 with chk 0x00 → write performed, err=1, done=0. A5 00 00 26 → err=1. A5 00 00 00 → done=1.
